// File: rtl/flop_mw_pipe.sv
// flop_mw_pipe: parametrised MEM/WB pipeline register.
//
// Carries writeback control, destination register, ALU result and memory read
// data through STAGES register slices. It supports stall (en=0), bubble
// insertion into slice 1 (flush), a valid bit, a registered writeback result
// mux and a saturating retired-instruction counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   en           1 = pipeline advances, 0 = all slices hold
//   flush        1 = slice 1 loads a bubble this edge
//   valid_m      memory-stage entry valid; 0 gates the entry into a bubble
//   pcsrc_m, regwrite_m, memtoreg_m, wa3_m, aluout_m, readdata_m
//                memory-stage entry fields
//   valid_w, pcsrc_w, regwrite_w, memtoreg_w, wa3_w, aluout_w, readdata_w
//                final-slice fields
//   result_w     registered writeback value (readdata_w or aluout_w)
//   retired_cnt  saturating count of valid entries written into the final slice
module flop_mw_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RA_WIDTH  = 4,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 valid_m,
  input  logic                 pcsrc_m,
  input  logic                 regwrite_m,
  input  logic                 memtoreg_m,
  input  logic [RA_WIDTH-1:0]  wa3_m,
  input  logic [WIDTH-1:0]     aluout_m,
  input  logic [WIDTH-1:0]     readdata_m,
  output logic                 valid_w,
  output logic                 pcsrc_w,
  output logic                 regwrite_w,
  output logic                 memtoreg_w,
  output logic [RA_WIDTH-1:0]  wa3_w,
  output logic [WIDTH-1:0]     aluout_w,
  output logic [WIDTH-1:0]     readdata_w,
  output logic [WIDTH-1:0]     result_w,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam int NumStages = int'(STAGES);

  if (STAGES < 1 || STAGES > 4) begin : gen_stages_check
    $error("flop_mw_pipe: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic                valid;
    logic                pcsrc;
    logic                regwrite;
    logic                memtoreg;
    logic [RA_WIDTH-1:0] wa3;
    logic [WIDTH-1:0]    aluout;
    logic [WIDTH-1:0]    readdata;
  } slice_t;

  slice_t               slice_q [NumStages];
  slice_t               slice_d [NumStages];
  slice_t               in_entry;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // An invalid entry never carries control or data into the pipe.
  always_comb begin
    in_entry = '0;
    if (valid_m) begin
      in_entry.valid    = 1'b1;
      in_entry.pcsrc    = pcsrc_m;
      in_entry.regwrite = regwrite_m;
      in_entry.memtoreg = memtoreg_m;
      in_entry.wa3      = wa3_m;
      in_entry.aluout   = aluout_m;
      in_entry.readdata = readdata_m;
    end
  end

  always_comb begin
    for (int k = 0; k < NumStages; k++) begin
      slice_d[k] = slice_q[k];
    end
    // Flush beats stall, but only for slice 1.
    if (flush) begin
      slice_d[0] = '0;
    end else if (en) begin
      slice_d[0] = in_entry;
    end
    if (en) begin
      for (int k = 1; k < NumStages; k++) begin
        slice_d[k] = slice_q[k-1];
      end
    end
  end

  // The result is muxed from whatever is loaded into the final slice, so it
  // always lines up with the other _w fields. A held slice reproduces the
  // held result, and a bubble yields 0.
  always_comb begin
    result_d = slice_d[NumStages-1].memtoreg ? slice_d[NumStages-1].readdata
                                             : slice_d[NumStages-1].aluout;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (en && slice_d[NumStages-1].valid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NumStages; k++) begin
        slice_q[k] <= '0;
      end
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int k = 0; k < NumStages; k++) begin
        slice_q[k] <= slice_d[k];
      end
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    valid_w     = slice_q[NumStages-1].valid;
    pcsrc_w     = slice_q[NumStages-1].pcsrc;
    regwrite_w  = slice_q[NumStages-1].regwrite;
    memtoreg_w  = slice_q[NumStages-1].memtoreg;
    wa3_w       = slice_q[NumStages-1].wa3;
    aluout_w    = slice_q[NumStages-1].aluout;
    readdata_w  = slice_q[NumStages-1].readdata;
    result_w    = result_q;
    retired_cnt = cnt_q;
  end

endmodule
